// File: rtl/fir_tap_loader.sv
// fir_tap_loader: shadow tap bank that bursts its coefficients into a FIR and tracks settling
//   i_cfg_wr/i_cfg_addr/i_cfg_data : host writes into the shadow bank (dropped while busy -> o_cfg_drop)
//   i_load                         : commit the shadow bank to the FIR (ignored while busy)
//   o_tap_wr/o_tap                 : back-to-back tap burst, highest index first
//   i_ce/o_ce                      : sample strobe pass-through (gated during a burst with FIR_TAPLOAD_CE_GATE_EN)
//   o_busy/o_valid                 : burst in progress / FIR output reflects only the current taps
module fir_tap_loader #(
    parameter int NTAPS   = 16,
    parameter int LGNTAPS = 4,
    parameter int TW      = 12
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_cfg_wr,
    input  logic [LGNTAPS-1:0] i_cfg_addr,
    input  logic [TW-1:0]      i_cfg_data,
    output logic               o_cfg_drop,
    input  logic               i_load,
    output logic               o_busy,
    input  logic               i_ce,
    output logic               o_ce,
    output logic               o_tap_wr,
    output logic [TW-1:0]      o_tap,
    output logic               o_valid
);
    typedef enum logic [1:0] {IDLE, LOAD, SETTLE} state_t;
    localparam logic [LGNTAPS:0] ONE  = (LGNTAPS+1)'(1);
    localparam logic [LGNTAPS:0] FULL = (LGNTAPS+1)'(NTAPS);
    state_t             state_q, state_d;
    logic [LGNTAPS:0]   idx_q, idx_d, settle_q, settle_d;
    logic [TW-1:0]      shadow_q [NTAPS];
    logic [TW-1:0]      tap_q, tap_d;
    logic               tap_wr_q, tap_wr_d, valid_q, valid_d, drop_q, drop_d;
    logic               busy, ce;
    logic [LGNTAPS-1:0] rd_addr;

    assign busy    = state_q == LOAD;
`ifdef FIR_TAPLOAD_CE_GATE_EN
    assign ce      = i_ce & ~busy;
`else
    assign ce      = i_ce;
`endif
    // idx counts 0..NTAPS; its low bits inverted give the descending read address
    assign rd_addr = ~idx_q[LGNTAPS-1:0];

    always_ff @(posedge i_clk)
        if (i_cfg_wr && !busy) shadow_q[i_cfg_addr] <= i_cfg_data;

    always_ff @(posedge i_clk)
        state_q <= !i_reset_n ? IDLE : state_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = i_load ? LOAD : IDLE;
            LOAD:    state_d = idx_q[LGNTAPS] ? SETTLE : LOAD;
            SETTLE:  state_d = i_load ? LOAD : (ce && settle_q == ONE) ? IDLE : SETTLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        idx_d    = busy ? idx_q + ONE : idx_q;
        tap_wr_d = busy && !idx_q[LGNTAPS];
        tap_d    = tap_wr_d ? shadow_q[rd_addr] : tap_q;
        drop_d   = i_cfg_wr && busy;
        valid_d  = valid_q;
        settle_d = settle_q;
        if (state_d == LOAD && !busy) begin
            idx_d   = '0;
            valid_d = 1'b0;
        end
        if (busy && state_d == SETTLE) settle_d = FULL;
        else if (state_q == SETTLE && ce) settle_d = settle_q - ONE;
        if (state_q == SETTLE && state_d == IDLE) valid_d = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            idx_q    <= '0;
            settle_q <= '0;
            tap_q    <= '0;
            tap_wr_q <= 1'b0;
            valid_q  <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            idx_q    <= idx_d;
            settle_q <= settle_d;
            tap_q    <= tap_d;
            tap_wr_q <= tap_wr_d;
            valid_q  <= valid_d;
            drop_q   <= drop_d;
        end
    end

    assign o_busy     = busy;
    assign o_ce       = ce;
    assign o_tap      = tap_q;
    assign o_tap_wr   = tap_wr_q;
    assign o_valid    = valid_q;
    assign o_cfg_drop = drop_q;
endmodule
